// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared widths and state encoding for the fetch sequencer
package fetch_sequencer_pkg;

    localparam int WIDTH       = 16;
    localparam int INSTR_BYTES = 2;

    localparam logic [1:0] ST_ISSUE      = 2'd0;
    localparam logic [1:0] ST_FETCH_RESP = 2'd1;
    localparam logic [1:0] ST_DATA_RESP  = 2'd2;

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and shares one sync-read memory port between fetch and data accesses
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int               WIDTH          = fetch_sequencer_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC       = '0,
    parameter int               MAX_DATA_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             dmem_req,
    input  logic             dmem_we,
    input  logic [WIDTH-1:0] dmem_addr,
    input  logic [WIDTH-1:0] dmem_wdata,
    output logic             dmem_grant,
    output logic             dmem_rvalid,
    output logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] ir,
    output logic             ir_valid,
    output logic [WIDTH-1:0] currpc,
    output logic [WIDTH-1:0] newpc
);

    localparam int               CW        = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CW-1:0]    BURST_MAX = CW'(MAX_DATA_BURST);
    localparam logic [WIDTH-1:0] PC_RST    = RESET_PC & ~WIDTH'(1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    burst_cnt;
    logic [WIDTH-1:0] pc, pc_inc, branch_pc;
    logic             data_go, fetch_go, fetch_done;

    // arbitration: data wins unless its burst allowance is spent while fetch waits
    always_comb begin
        pc_inc     = pc + WIDTH'(INSTR_BYTES);
        branch_pc  = branch_target & ~WIDTH'(1);
        data_go    = (state == ST_ISSUE) && dmem_req && !(burst_cnt == BURST_MAX && fetch_en);
        fetch_go   = (state == ST_ISSUE) && !data_go && fetch_en && !branch_taken;
        fetch_done = (state == ST_FETCH_RESP) && !branch_taken;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_ISSUE;
        else
            state <= state_nxt;
    end

    // next state: reads wait a cycle for data, writes complete in the issue cycle
    always_comb begin
        state_nxt = ST_ISSUE;
        if (data_go)
            state_nxt = dmem_we ? ST_ISSUE : ST_DATA_RESP;
        else if (fetch_go)
            state_nxt = ST_FETCH_RESP;
    end

    // memory port and data-side handshake
    always_comb begin
        dmem_grant  = data_go;
        dmem_rvalid = (state == ST_DATA_RESP);
        dmem_rdata  = dmem_rvalid ? mem_rdata : '0;
        mem_addr    = data_go ? dmem_addr : pc;
        mem_we      = data_go && dmem_we;
        mem_wdata   = data_go ? dmem_wdata : '0;
    end

    // PC: a redirect in any state wins over the sequential advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc <= PC_RST;
        else if (branch_taken)
            pc <= branch_pc;
        else if (fetch_done)
            pc <= pc_inc;
    end

    // consecutive data grants, cleared whenever a fetch gets the port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            burst_cnt <= '0;
        else if (data_go)
            burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CW'(1);
        else if (fetch_go)
            burst_cnt <= '0;
    end

    // decode-facing instruction registers, updated only by an unsquashed fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir       <= '0;
            ir_valid <= 1'b0;
            currpc   <= '0;
            newpc    <= PC_RST;
        end else begin
            ir_valid <= fetch_done;
            if (fetch_done) begin
                ir     <= mem_rdata;
                currpc <= pc;
                newpc  <= pc_inc;
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller for the single-port, synchronous-read instruction/data memory.
- Owns the PC register and sequences instruction fetches into the decode-facing outputs ir/currpc/newpc.
- Arbitrates the same memory port between fetch and data-side load/store requests from later stages.
- Sits between the top-level pipeline control (fetch_en, branch redirect) and the memory component.

Parameters:
WIDTH, 16, address/data/instruction width
RESET_PC, 16'h0000, PC value loaded on reset (bit 0 forced 0)
MAX_DATA_BURST, 4, consecutive data grants allowed before one fetch is forced ahead

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
fetch_en  in  1  permit issuing instruction fetches
branch_taken  in  1  redirect PC this cycle
branch_target  in  WIDTH  redirect address (bit 0 ignored)
dmem_req  in  1  data access request, held until granted
dmem_we  in  1  1 = write, 0 = read
dmem_addr  in  WIDTH  data address
dmem_wdata  in  WIDTH  write data
dmem_grant  out  1  data request accepted this cycle (comb)
dmem_rvalid  out  1  read data valid (comb, DATA_RESP only)
dmem_rdata  out  WIDTH  read data (= mem_rdata in DATA_RESP, else 0)
mem_addr  out  WIDTH  memory address (comb)
mem_we  out  1  memory write strobe (comb)
mem_wdata  out  WIDTH  memory write data (comb)
mem_rdata  in  WIDTH  memory read data, valid the cycle after address
ir  out  WIDTH  fetched instruction (registered, held)
ir_valid  out  1  one-cycle pulse: ir/currpc/newpc updated
currpc  out  WIDTH  address of ir (registered)
newpc  out  WIDTH  currpc + 2 (registered)

Behaviour:
- Reset (rst low, async):
  - pc = RESET_PC; state = ISSUE; burst_cnt = 0.
  - ir = 0, ir_valid = 0, currpc = 0, newpc = RESET_PC.
- Memory port defaults: mem_we = 0, mem_addr = pc, mem_wdata = 0 when not driving a data write.
- States: ISSUE, FETCH_RESP, DATA_RESP.
- ISSUE:
  - Priority 1, data: dmem_req && !(burst_cnt == MAX_DATA_BURST && fetch_en).
    - Drive mem_addr = dmem_addr, mem_we = dmem_we, mem_wdata = dmem_wdata; dmem_grant = 1; burst_cnt++ (saturates).
    - Write: stay in ISSUE. Read: go to DATA_RESP.
  - Priority 2, fetch: else if fetch_en && !branch_taken.
    - mem_addr = pc; go to FETCH_RESP; burst_cnt = 0.
  - Otherwise idle, stay in ISSUE.
  - A branch_taken in ISSUE loads pc = {branch_target[WIDTH-1:1],0} and suppresses the fetch issue that cycle. A data grant may still occur in the same cycle.
- FETCH_RESP, no branch_taken:
  - ir = mem_rdata, currpc = pc, newpc = pc+2, pc = pc+2 (mod 2^WIDTH), ir_valid = 1.
  - Go to ISSUE.
- FETCH_RESP with branch_taken (squash):
  - ir, currpc, newpc unchanged; ir_valid = 0; pc = target.
  - Go to ISSUE.
- DATA_RESP:
  - dmem_rvalid = 1, dmem_rdata = mem_rdata; go to ISSUE.
  - A branch_taken here only updates pc.
- fetch_en low: no new fetch issued. An in-flight fetch still completes.
- Fetch throughput is one instruction per 2 cycles when uncontended. Latency from issue to ir_valid is 1 cycle.
- PC wrap: 16'hFFFE + 2 = 16'h0000. newpc is computed with the same wrap.
- ir_valid is 0 in every cycle other than a completed FETCH_RESP.
- Reset asserted mid-access abandons the access: no grant or rvalid after reset. After reset release, the first fetch is from RESET_PC.

Decomposition:
- Shared package holds:
  - state encoding localparams: ST_ISSUE = 2'd0, ST_FETCH_RESP = 2'd1, ST_DATA_RESP = 2'd2.
  - INSTR_BYTES = 2.
  - the WIDTH default.
- No sub-module. The PC/next-PC logic stays inline; the arbitration is a single FSM.

Test Plan:
- Reset, fetch_en = 1, mem returns 16'h1234 then 16'h5678 → mem_addr 0 then 2. ir_valid pulses on cycles 2 and 4. ir = 16'h1234 with currpc = 0, newpc = 2; then ir = 16'h5678 with currpc = 2, newpc = 4.
- branch_taken = 1, target 16'h0041, asserted during FETCH_RESP of pc = 4 → no ir_valid that cycle. The next fetch address is 16'h0040, then currpc = 16'h0040, newpc = 16'h0042.
- Concurrent requests, dmem_req read at addr 16'h0100 (mem returns 16'hBEEF), fetch_en = 1 → grant first. The next cycle has dmem_rvalid = 1 and dmem_rdata = 16'hBEEF. The fetch issues afterwards.
- Starvation limit, dmem_req held high with writes and fetch_en = 1 → exactly 4 consecutive grants, then one fetch issue with dmem_grant = 0, then grants resume.
- Wrap, RESET_PC = 16'hFFFE → first currpc = 16'hFFFE, newpc = 16'h0000, next fetch at 16'h0000.
- Reset mid-access, rst pulled low during DATA_RESP → outputs at reset values immediately (async). After release, no dmem_rvalid occurs and the fetch restarts at RESET_PC.
